// File: rtl/cpu_pkg.sv
// Shared types and helpers for the accumulator CPU sequencer.
// Opcode and phase encodings plus the ALU-class opcode test.
package cpu_pkg;

    localparam int OPC_W   = 3;
    localparam int PHASE_W = 3;

    typedef enum logic [OPC_W-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [PHASE_W-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) ||
               (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Eight-phase wrapping counter for the CPU sequencer.
// hold_i freezes the count; reset always wins.
module phase_counter
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold_i,
    output logic [PHASE_W-1:0] phase_o
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    // Next count: advance by one unless held.
    always_comb begin
        phase_d = phase_q;
        if (!hold_i) begin
            phase_d = phase_q + 1'b1;
        end
    end

    // Phase register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/cpu_controller.sv
// Fetch/execute sequencer for the 8-bit accumulator CPU.
// Decodes phase, opcode and zero into datapath strobes.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               zero,
    output logic [PHASE_W-1:0] phase,
    output logic               sel,
    output logic               rd,
    output logic               ld_ir,
    output logic               halt,
    output logic               inc_pc,
    output logic               ld_pc,
    output logic               ld_ac,
    output logic               wr,
    output logic               data_e
);

    opcode_t op;
    phase_t  ph;
    logic    alu;
    logic    halt_q;
    logic    halt_d;

    assign op  = opcode_t'(opcode);
    assign alu = is_aluop(op);

    // The counter stops as soon as halt shows, so it stays in OP_ADDR.
    phase_counter u_phase (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (halt),
        .phase_o (phase)
    );

    assign ph = phase_t'(phase);

    // Sticky halt: set leaving OP_ADDR on HLT, cleared only by reset.
    always_comb begin
        halt_d = halt_q | ((ph == OP_ADDR) && (op == HLT));
    end

    // Halt flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    // Strobe decode; once halted only the halt indicator stays up.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        if (halt_q) begin
            halt = 1'b1;
        end else begin
            unique case (ph)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (op == HLT);
                end
                OP_FETCH: begin
                    rd = alu;
                end
                ALU_OP: begin
                    rd     = alu;
                    inc_pc = (op == SKZ) && zero;
                    ld_pc  = (op == JMP);
                    data_e = (op == STO);
                end
                STORE: begin
                    rd     = alu;
                    ld_ac  = alu;
                    ld_pc  = (op == JMP);
                    wr     = (op == STO);
                    data_e = (op == STO);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller.
// Per-cycle expected strobe vectors are queued and checked at negedge.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic [2:0] phase;
    logic       sel, rd, ld_ir, halt, inc_pc;
    logic       ld_pc, ld_ac, wr, data_e;

    // {phase, halt, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e}
    typedef logic [11:0] vec_t;

    typedef struct packed {
        logic [7:0] sel;
        logic [7:0] rd;
        logic [7:0] ldir;
        logic [7:0] inc;
        logic [7:0] ldpc;
        logic [7:0] ldac;
        logic [7:0] wr;
        logic [7:0] de;
    } masks_t;

    vec_t q[$];
    int   errors = 0;
    int   checks = 0;

    masks_t m_alu, m_skz1, m_skz0, m_sto, m_jmp, m_hlt;

    cpu_controller dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .zero   (zero),
        .phase  (phase),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .halt   (halt),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e)
    );

    always #5 clk = ~clk;

    function automatic masks_t mkm(
        input logic [7:0] rdm, incm, ldpcm,
        input logic [7:0] ldacm, wrm, dem
    );
        masks_t m;
        m.sel  = 8'h0F;
        m.ldir = 8'h0C;
        m.rd   = rdm;
        m.inc  = incm;
        m.ldpc = ldpcm;
        m.ldac = ldacm;
        m.wr   = wrm;
        m.de   = dem;
        return m;
    endfunction

    function automatic vec_t vec(
        input int p, input masks_t m, input logic h
    );
        logic [2:0] pp;
        pp = p[2:0];
        return {pp, h, m.sel[p], m.rd[p], m.ldir[p],
                m.inc[p], m.ldpc[p], m.ldac[p],
                m.wr[p], m.de[p]};
    endfunction

    task automatic step(input vec_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(
        input logic [2:0] op, input logic z, input masks_t m
    );
        opcode = op;
        zero   = z;
        for (int p = 0; p < 8; p++) step(vec(p, m, 1'b0));
    endtask

    // Monitor: compare the DUT against the head of the queue.
    always @(negedge clk) begin
        vec_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {phase, halt, sel, rd, ld_ir, inc_pc,
                 ld_pc, ld_ac, wr, data_e};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL strobes #%0d: got %b want %b",
                         checks, a, e);
            end
            if (rd && wr) begin
                errors++;
                $display("FAIL excl_rd_wr #%0d: both 1", checks);
            end
            if (ld_pc && inc_pc) begin
                errors++;
                $display("FAIL excl_pc #%0d: both 1", checks);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        m_alu  = mkm(8'hEE, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00);
        m_skz1 = mkm(8'h0E, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00);
        m_skz0 = mkm(8'h0E, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
        m_sto  = mkm(8'h0E, 8'h10, 8'h00, 8'h00, 8'h80, 8'hC0);
        m_jmp  = mkm(8'h0E, 8'h10, 8'hC0, 8'h00, 8'h00, 8'h00);
        m_hlt  = mkm(8'h0E, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);

        rst_n  = 1'b0;
        opcode = 3'd0;
        zero   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run(3'd5, 1'b0, m_alu);
        run(3'd2, 1'b1, m_alu);
        run(3'd3, 1'b0, m_alu);
        run(3'd4, 1'b0, m_alu);
        run(3'd1, 1'b1, m_skz1);
        run(3'd1, 1'b0, m_skz0);
        run(3'd6, 1'b1, m_sto);
        run(3'd7, 1'b1, m_jmp);

        // ADD interrupted by reset in phase 6.
        opcode = 3'd2;
        zero   = 1'b0;
        for (int p = 0; p < 6; p++) step(vec(p, m_alu, 1'b0));
        rst_n = 1'b0;
        step(vec(6, m_alu, 1'b0));
        rst_n = 1'b1;
        run(3'd5, 1'b0, m_alu);

        // HLT: freeze at phase 4, inputs changing underneath.
        opcode = 3'd0;
        for (int p = 0; p < 4; p++) step(vec(p, m_hlt, 1'b0));
        step(vec(4, m_hlt, 1'b1));
        opcode = 3'd5;
        zero   = 1'b1;
        repeat (24) step({3'd4, 1'b1, 8'h00});
        rst_n = 1'b0;
        step({3'd4, 1'b1, 8'h00});
        rst_n = 1'b1;
        run(3'd5, 1'b0, m_alu);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d left want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Sequencer for the 8-bit accumulator CPU. Runs an 8-phase fetch/execute cycle and drives all datapath strobes.
- Its ld_ac output is the load-enable of the accumulator, one stage downstream.
- Decodes the 3-bit opcode from the instruction register and the accumulator-zero flag.
- Generates memory, PC, IR and accumulator control, and halts on HLT.

Parameters:
- OPC_W, 3, opcode width (fixed encoding in package).
- PHASE_W, 3, phase counter width (8 phases).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- opcode  input  OPC_W  opcode field from the instruction register; stable from phase 3 to phase 7.
- zero  input  1  accumulator == 0; sampled in phase 6.
- phase  output  PHASE_W  current phase (debug / bench).
- sel  output  1  address mux: 1 = PC, 0 = IR operand.
- rd  output  1  memory read.
- ld_ir  output  1  instruction register load.
- halt  output  1  sticky halt indicator.
- inc_pc  output  1  PC increment.
- ld_pc  output  1  PC load (jump).
- ld_ac  output  1  accumulator load enable.
- wr  output  1  memory write.
- data_e  output  1  accumulator drives data bus.

Behaviour:
- Reset is synchronous and active-low. rst_n=0 at a rising edge forces the following:
  - phase=0 and the halt flag cleared.
  - All outputs take their phase-0 values: sel=1, all others 0.
- Reset has priority over everything, including mid-instruction and while halted.
- The phase counter increments by 1 every clock and wraps from 7 to 0. It is frozen while halted.
- Outputs are a combinational decode of the registered phase, the halt flag, opcode and zero. The resulting strobe acts on the next rising edge.
- Opcode encoding: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP is defined as ADD, AND, XOR or LDA.
- Phase decode (any strobe not listed is 0):
  - Phase 0 INST_ADDR: sel=1.
  - Phase 1 INST_FETCH: sel=1, rd=1.
  - Phase 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - Phase 3 IDLE: sel=1, rd=1, ld_ir=1.
  - Phase 4 OP_ADDR: inc_pc=1, halt=(opcode==HLT).
  - Phase 5 OP_FETCH: rd=ALUOP.
  - Phase 6 ALU_OP: rd=ALUOP, inc_pc=(SKZ && zero), ld_pc=JMP, data_e=STO.
  - Phase 7 STORE: rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO.
- Halt:
  - The clock edge ending phase 4 with opcode==HLT sets the sticky halt register.
  - From then on: phase is held at 4 and halt=1. All other strobes are 0, including inc_pc, so no extra increment occurs.
  - The only exit from halt is reset.
- ld_ac:
  - Asserts for exactly one cycle per ALUOP instruction, in phase 7.
  - It never asserts for SKZ, STO, JMP or HLT.
- Mutual exclusion:
  - wr and rd are never both 1.
  - ld_pc and inc_pc are never both 1.
- Latency: one instruction every 8 clocks. The first ld_ac after reset release arrives at cycle 7.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode_t enum (3-bit, values above).
  - phase_t enum (INST_ADDR..STORE).
  - An is_aluop() function.
  - The widths OPC_W and PHASE_W.
- Natural sub-module: phase_counter. It is a 3-bit wrapping counter with sync active-low reset and a hold input driven by halt.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release → phase=0, sel=1, all other strobes 0; phase then steps 0..7, then 0.
- LDA (opcode=5): ld_ac=1 only in phase 7; rd=1 in phases 1,2,3,5,6,7; inc_pc=1 only in phase 4.
- SKZ (opcode=1), run once with zero=1 and once with zero=0:
  - zero=1 → inc_pc=1 in phases 4 and 6.
  - zero=0 → inc_pc=1 only in phase 4.
  - ld_ac=0 throughout.
- STO (opcode=6) → data_e=1 in phases 6–7, wr=1 only in phase 7, rd=0 in phases 5–7. JMP (opcode=7) → ld_pc=1 in phases 6–7.
- HLT (opcode=0) → halt=1 from phase 4 onward; phase frozen at 4 for 20+ cycles; no further strobes. Then rst_n=0 → halt=0, phase=0.
- Reset mid-instruction: assert rst_n=0 during phase 6 of ADD → no ld_ac pulse; phase=0 on the next edge.
